// File: rtl/conv_mac_stream.sv
// rtl/conv_mac_stream.sv - streaming multiply-accumulate engine, one convolution sum per kernel window
module conv_mac_stream #(
    parameter int DATA_W   = 8,
    parameter int TAPS     = 36,
    parameter int CHANNELS = 1,
    parameter int SUM_W    = 22,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              packetRead,
    input  logic [DATA_W-1:0] image,
    input  logic [DATA_W-1:0] pattern,
    input  logic              relu_en,
    output logic [SUM_W-1:0]  convSum,
    output logic              sumValid,
    input  logic              sumReady
);

    localparam int N      = TAPS * CHANNELS;
    localparam int CNT_W  = $clog2(N + 1);
    localparam int PROD_W = 2 * DATA_W;
    // Working width covers the larger of accumulator and product plus headroom for overflow detection
    localparam int EXT_W  = ((SUM_W > PROD_W) ? SUM_W : PROD_W) + 2;
    localparam logic SGN  = (SIGNED != 0);
    localparam logic SAT  = (SATURATE != 0);

    localparam logic [EXT_W-1:0] ONE     = EXT_W'(1);
    localparam logic [EXT_W-1:0] MAX_EXT = SGN ? ((ONE << (SUM_W - 1)) - ONE) : ((ONE << SUM_W) - ONE);
    localparam logic [EXT_W-1:0] MIN_EXT = SGN ? ~((ONE << (SUM_W - 1)) - ONE) : '0;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         drain_q, drain_d;
    logic [PROD_W-1:0]  prod_q, prod_d;
    logic               prod_vld_q, prod_vld_d;
    logic [SUM_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic               relu_q, relu_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic [PROD_W-1:0]  mul_s, mul_u;
    logic [EXT_W-1:0]   acc_ext, prod_ext, sum_ext;
    logic               ovf_hi, ovf_lo;
    logic [SUM_W-1:0]   result;

    assign accept = enable && (state_q == S_ACCUM);

    assign mul_u = {{DATA_W{1'b0}}, image} * {{DATA_W{1'b0}}, pattern};
    assign mul_s = $signed({{DATA_W{image[DATA_W-1]}}, image}) *
                   $signed({{DATA_W{pattern[DATA_W-1]}}, pattern});

    assign acc_ext  = {{(EXT_W - SUM_W){SGN & acc_q[SUM_W-1]}}, acc_q};
    assign prod_ext = {{(EXT_W - PROD_W){SGN & prod_q[PROD_W-1]}}, prod_q};
    assign sum_ext  = acc_ext + prod_ext;

    always_comb begin
        ovf_hi = 1'b0;
        ovf_lo = 1'b0;
        if (SGN) begin
            ovf_hi = $signed(sum_ext) > $signed(MAX_EXT);
            ovf_lo = $signed(sum_ext) < $signed(MIN_EXT);
        end else begin
            ovf_hi = sum_ext > MAX_EXT;
        end
    end

    // ReLU acts on the already-saturated accumulator
    assign result = (SGN && relu_q && acc_q[SUM_W-1]) ? '0 : acc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        prod_d     = prod_q;
        prod_vld_d = accept;
        acc_d      = acc_q;
        sat_d      = sat_q;
        relu_d     = relu_q;
        sum_d      = sum_q;
        valid_d    = valid_q;

        if (accept) begin
            prod_d = SGN ? mul_s : mul_u;
        end

        // Once clamped, the window result stays pinned at the bound
        if (prod_vld_q && !sat_q) begin
            if (SAT && ovf_hi) begin
                acc_d = MAX_EXT[SUM_W-1:0];
                sat_d = 1'b1;
            end else if (SAT && ovf_lo) begin
                acc_d = MIN_EXT[SUM_W-1:0];
                sat_d = 1'b1;
            end else begin
                acc_d = sum_ext[SUM_W-1:0];
            end
        end

        case (state_q)
            S_IDLE: begin
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == '0) begin
                        relu_d = relu_en;
                    end
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd2) begin
                    state_d = S_OUT;
                    sum_d   = result;
                    valid_d = 1'b1;
                end
            end
            S_OUT: begin
                if (sumReady) begin
                    valid_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            sat_q      <= 1'b0;
            relu_q     <= 1'b0;
            sum_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            acc_q      <= acc_d;
            sat_q      <= sat_d;
            relu_q     <= relu_d;
            sum_q      <= sum_d;
            valid_q    <= valid_d;
        end
    end

    assign packetRead = (state_q == S_ACCUM);
    assign convSum    = sum_q;
    assign sumValid   = valid_q;

endmodule

// File: tb/tb_conv_mac_stream.sv
// tb/tb_conv_mac_stream.sv - bench for conv_mac_stream across unsigned, signed-saturating and wrapping builds
module tb_conv_mac_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        relu_en = 1'b0;
    logic        sumReady = 1'b0;
    logic [7:0]  image = '0;
    logic [7:0]  pattern = '0;

    logic        pr_a, sv_a, pr_b, sv_b, pr_c, sv_c;
    logic [21:0] cs_a;
    logic [15:0] cs_b, cs_c;

    always #5 clk = ~clk;

    // A: defaults; B: signed 16-bit saturating, 18-sample window; C: unsigned 16-bit wrapping, 9x4 window
    conv_mac_stream dut_a (
        .clk(clk), .rst(rst), .enable(enable), .packetRead(pr_a), .image(image), .pattern(pattern),
        .relu_en(relu_en), .convSum(cs_a), .sumValid(sv_a), .sumReady(sumReady));

    conv_mac_stream #(.TAPS(9), .CHANNELS(2), .SUM_W(16), .SIGNED(1), .SATURATE(1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .packetRead(pr_b), .image(image), .pattern(pattern),
        .relu_en(relu_en), .convSum(cs_b), .sumValid(sv_b), .sumReady(sumReady));

    conv_mac_stream #(.TAPS(9), .CHANNELS(4), .SUM_W(16), .SIGNED(0), .SATURATE(0)) dut_c (
        .clk(clk), .rst(rst), .enable(enable), .packetRead(pr_c), .image(image), .pattern(pattern),
        .relu_en(relu_en), .convSum(cs_c), .sumValid(sv_c), .sumReady(sumReady));

    int         n_cmp = 0;
    int         n_bad = 0;
    int         sel = 0;
    logic [7:0] img_q [64];
    logic [7:0] pat_q [64];

    function automatic logic cur_pr();
        return (sel == 0) ? pr_a : (sel == 1) ? pr_b : pr_c;
    endfunction

    function automatic logic cur_sv();
        return (sel == 0) ? sv_a : (sel == 1) ? sv_b : sv_c;
    endfunction

    function automatic logic [63:0] cur_cs();
        return (sel == 0) ? 64'(cs_a) : (sel == 1) ? 64'(cs_b) : 64'(cs_c);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Window result from plain integer arithmetic: running sum, clamp (sticky), then mask and ReLU
    function automatic logic [63:0] model(input int n, input int w, input bit sgn, input bit sat, input bit relu);
        longint     s = 0;
        longint     p, mx, mn;
        bit         stuck = 0;
        logic [63:0] r;
        mx = sgn ? (longint'(1) <<< (w - 1)) - 1 : (longint'(1) <<< w) - 1;
        mn = sgn ? -(longint'(1) <<< (w - 1)) : 0;
        for (int i = 0; i < n; i++) begin
            if (sgn) p = longint'($signed(img_q[i])) * longint'($signed(pat_q[i]));
            else     p = longint'(img_q[i]) * longint'(pat_q[i]);
            if (!stuck) begin
                s += p;
                if (sat && s > mx) begin s = mx; stuck = 1; end
                else if (sat && s < mn) begin s = mn; stuck = 1; end
            end
        end
        r = 64'(s) & ((64'd1 << w) - 64'd1);
        if (relu && sgn && r[w-1]) r = '0;
        return r;
    endfunction

    task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 64; i++) begin
            img_q[i] = a;
            pat_q[i] = b;
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 64; i++) begin
            img_q[i] = 8'($urandom_range(0, 255));
            pat_q[i] = 8'($urandom_range(0, 255));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        sumReady = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_pr",  {61'd0, pr_a, pr_b, pr_c}, 64'd0);
        check("rst_sv",  {61'd0, sv_a, sv_b, sv_c}, 64'd0);
        check("rst_cs",  {26'd0, cs_a, cs_b, cs_c}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_exit_pr", {61'd0, pr_a, pr_b, pr_c}, 64'd7);
    endtask

    task automatic run_window(input string tag, input int n, input int w, input bit sgn, input bit sat,
                              input bit relu, input bit gaps, input int hold);
        logic [63:0] exp;
        int          k;
        exp = model(n, w, sgn, sat, relu);
        relu_en = relu;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = 1'b0;
            if (i == 1) relu_en = ~relu;
            if (gaps && $urandom_range(0, 1) == 1) @(negedge clk);
            k = 0;
            while (!cur_pr() && k < 50) begin
                @(negedge clk);
                k++;
            end
            if (!cur_pr()) check({tag, "_ready_timeout"}, 64'(cur_pr()), 64'd1);
            enable = 1'b1;
            image = img_q[i];
            pattern = pat_q[i];
        end
        @(negedge clk);
        enable = 1'b0;
        image = 8'($urandom);
        check({tag, "_pr_after_last"}, 64'(cur_pr()), 64'd0);
        k = 0;
        while (!cur_sv() && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'd3);
        check({tag, "_sum"}, cur_cs(), exp);
        for (int h = 0; h < hold; h++) begin
            enable = 1'b1;
            image = 8'($urandom);
            pattern = 8'($urandom);
            @(negedge clk);
            check({tag, "_hold"}, {cur_sv(), cur_pr(), cur_cs()[61:0]}, {2'b10, exp[61:0]});
        end
        enable = 1'b0;
        sumReady = 1'b1;
        @(negedge clk);
        sumReady = 1'b0;
        check({tag, "_handshake"}, {62'd0, cur_sv(), cur_pr()}, 64'd1);
    endtask

    initial begin
        do_reset();

        sel = 0;
        fill_const(8'd1, 8'd1);
        run_window("a_ones", 36, 22, 0, 1, 0, 0, 5);
        fill_const(8'd255, 8'd255);
        run_window("a_max", 36, 22, 0, 1, 0, 0, 1);
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            run_window("a_rand", 36, 22, 0, 1, 0, 1, $urandom_range(0, 4));
        end
        fill_rand();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            enable = 1'b1;
            image = img_q[i];
            pattern = pat_q[i];
        end
        do_reset();
        fill_const(8'd1, 8'd1);
        run_window("a_after_abort", 36, 22, 0, 1, 0, 0, 0);

        do_reset();
        sel = 1;
        fill_const(8'hFF, 8'd2);
        run_window("b_neg", 18, 16, 1, 1, 0, 0, 2);
        run_window("b_neg_relu", 18, 16, 1, 1, 1, 0, 0);
        fill_const(8'd127, 8'd127);
        run_window("b_sat_hi", 18, 16, 1, 1, 0, 0, 0);
        fill_const(8'h80, 8'd127);
        run_window("b_sat_lo", 18, 16, 1, 1, 0, 1, 0);
        fill_const(8'd127, 8'd127);
        for (int i = 9; i < 18; i++) img_q[i] = 8'h80;
        run_window("b_sticky", 18, 16, 1, 1, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            fill_rand();
            run_window("b_rand", 18, 16, 1, 1, 1'($urandom_range(0, 1)), 1, $urandom_range(0, 3));
        end

        do_reset();
        sel = 2;
        fill_const(8'd255, 8'd255);
        run_window("c_wrap", 36, 16, 0, 0, 0, 0, 0);
        fill_const(8'd1, 8'd1);
        run_window("c_ones_gaps", 36, 16, 0, 0, 0, 1, 5);
        fill_const(8'd1, 8'd2);
        run_window("c_twos", 36, 16, 0, 0, 0, 1, 0);
        for (int r = 0; r < 2; r++) begin
            fill_rand();
            run_window("c_rand", 36, 16, 0, 0, 0, 1, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
